// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial CLA adder.
// Used by cla_nibble_datapath and cla_serial_add_ctrl.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_datapath.sv
// Combinational 4-bit carry-lookahead slice.
// Generate/propagate terms feed flat lookahead carries.
module cla_nibble_datapath
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o = p ^ c[NIBBLE_W-1:0];
  assign c_o = c[NIBBLE_W];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder around one 4-bit CLA slice.
// Define CLA_SUB_EN to add a `sub` port for a-b via ~b and carry-in 1.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  cla_seq_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co;
  logic [WIDTH-1:0]    b_acc;
  logic                c_acc;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  cla_nibble_datapath u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_co)
  );

`ifdef CLA_SUB_EN
  assign b_acc = sub ? ~b : b;
  assign c_acc = sub ? 1'b1 : cin;
`else
  assign b_acc = b;
  assign c_acc = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_acc;
          carry_d = c_acc;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = nib_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl at WIDTH=16.
module tb_cla_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef CLA_SUB_EN
  logic        sub;
`endif

  int nvec;
  int nerr;

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ok(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Accept one operand set and run it to DONE, checking exact latency.
  task automatic run_to_done(input string tag, input logic [15:0] av,
                             input logic [15:0] bv, input logic cv,
                             input logic [15:0] es, input logic ec);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".ready_wait"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SUB_EN
    sub = 1'b0;
`endif
    #2;
    idle_ok("reset");
    chk("reset.sum", 32'(sum), 32'h0);
    chk("reset.cout", 32'(cout), 32'h0);
    #10 rst_n = 1'b1;
    step();

    run_to_done("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    step();
    idle_ok("t1.ret");

    run_to_done("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    step();
    idle_ok("t2.ret");

    run_to_done("t3", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0);
    step();
    run_to_done("t3b", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    step();
    run_to_done("t3c", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    step();

    // Backpressure in DONE with competing input traffic.
    out_ready = 1'b0;
    run_to_done("t4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4.hold_valid", 32'(out_valid), 32'd1);
      chk("t4.hold_sum", 32'(sum), 32'h8000);
      chk("t4.hold_cout", 32'(cout), 32'd0);
      chk("t4.hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    idle_ok("t4.ret");
    in_valid = 1'b0;
    step();
    idle_ok("t4.idle2");

    // Asynchronous reset at idx=2 of a run.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t5.pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    idle_ok("t5.rst");
    chk("t5.rst_sum", 32'(sum), 32'h0);
    chk("t5.rst_cout", 32'(cout), 32'h0);
    #2 rst_n = 1'b1;
    step();
    run_to_done("t5b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    step();
    idle_ok("t5b.ret");

`ifdef CLA_SUB_EN
    sub = 1'b1;
    run_to_done("t6a", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    step();
    run_to_done("t6b", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    step();
    sub = 1'b0;
    run_to_done("t6c", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
